msk_hpc2_arbiter: RTL
=====================

MSK_HPC2_ARBITER -- requirements
Module: msk_hpc2_arbiter

Interface
REQ-001 SHALL have parameter d, default 2: number of shares per masked bit.
REQ-002 SHALL have parameter N, default 4: number of requesters sharing one MSKand_hpc2 instance.
REQ-003 SHALL define localparam hpc2rnd = d*(d-1)/2: random bits consumed per gate evaluation.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  N  per-requester operation request.
REQ-007 req_ready  output  N  per-requester grant (one-hot or zero).
REQ-008 req_ina  input  N*d  operand A sharing; requester i uses bits [i*d +: d].
REQ-009 req_inb  input  N*d  operand B sharing; requester i uses bits [i*d +: d].
REQ-010 rnd_in  input  hpc2rnd  fresh randomness.
REQ-011 rnd_valid  input  1  rnd_in holds fresh bits.
REQ-012 rnd_ready  output  1  rnd_in consumed this cycle.
REQ-013 gate_ina  output  d  to shared gate ina (latency-1 port).
REQ-014 gate_inb  output  d  to shared gate inb (latency-0 port).
REQ-015 gate_rnd  output  hpc2rnd  to shared gate rnd (latency 0).
REQ-016 gate_out  input  d  shared gate output (latency 2 after inb).
REQ-017 resp_valid  output  N  one-hot pulse: resp_out belongs to requester i.
REQ-018 resp_out  output  d  result sharing, combinational copy of gate_out.

Function
REQ-019 SHALL issue (cycle T) only when rnd_valid=1 and at least one req_valid=1; otherwise no grant and rnd_ready=0.
REQ-020 SHALL grant by round-robin: search starts at pointer p, first asserted req_valid at index >= p (wrapping) wins; p becomes winner+1 mod N after each issue.
REQ-021 On issue in cycle T: req_ready[winner]=1, rnd_ready=1, gate_inb=req_inb[winner], gate_rnd=rnd_in (combinational, same cycle).
REQ-022 SHALL register req_ina[winner] at T and drive it on gate_ina in cycle T+1 (ina latency 1).
REQ-023 SHALL track each issue with a 2-stage tag pipeline (valid + log2(N)-bit index); resp_valid[tag] asserted exactly in cycle T+2, one cycle only.
REQ-024 SHALL sustain one issue per cycle; back-to-back issues produce back-to-back responses in issue order.
REQ-025 Responses SHALL NOT be back-pressured; requesters accept resp_valid unconditionally.
REQ-026 req_ready SHALL never assert for a requester with req_valid=0; at most one bit set.
REQ-027 rnd_in bits SHALL be consumed at most once: rnd_ready asserts only together with a grant.
REQ-028 rnd_valid dropping mid-stream SHALL stall issue only; in-flight tags still complete on schedule.
REQ-029 N=1 SHALL degenerate to grant whenever req_valid and rnd_valid are both high.

Reset
REQ-030 While rst=1: req_ready=0, rnd_ready=0, resp_valid=0, p=0, tag pipeline cleared, registered ina=0.
REQ-031 Operations in flight when rst asserts SHALL be discarded; no resp_valid for them after reset releases.
REQ-032 First issue SHALL be possible in the first cycle with rst=0.

Configuration
REQ-033 Macro MSK_ARB_IDLE_ZERO_EN: when defined, gate_inb and gate_rnd SHALL be driven to 0 in cycles without issue, and gate_ina to 0 in cycles not following an issue, so no stale share reaches the gate.
REQ-034 Without MSK_ARB_IDLE_ZERO_EN, gate_inb/gate_rnd/gate_ina SHALL reflect the mux/register contents unchanged (lower area; idle values unspecified but stable-logic only).

Verification
REQ-035 d=2,N=4, after reset only req_valid=4'b0100, rnd_valid=1 -> req_ready=4'b0100, rnd_ready=1 at T; resp_valid=4'b0100 at T+2; p=3.
REQ-036 All four requesters valid for 8 cycles, rnd_valid=1 -> grants 0,1,2,3,0,1,2,3; responses identical order delayed 2 cycles.
REQ-037 req_valid=4'b1111, rnd_valid=0 for 3 cycles -> req_ready=0, rnd_ready=0 throughout; first grant to index 0 when rnd_valid rises.
REQ-038 Functional: requester 1 sends a=1 (shares 2'b10), b=0 (shares 2'b11) via inverted-share model of gate -> unmasked XOR of resp_out equals a AND b for all 4 input combinations with random masks.
REQ-039 Issue at T, rst=1 at T+1 -> no resp_valid at T+2 or later; all outputs zero during reset.
REQ-040 With MSK_ARB_IDLE_ZERO_EN, idle cycle after issue at T: gate_inb=0, gate_rnd=0 at T+1, gate_ina=0 at T+2.

Source files
------------

// File: rtl/msk_hpc2_arbiter.sv
// Round-robin arbiter sharing one MSKand_hpc2 gate among N requesters, with a 2-stage tag pipeline.
// Optional MSK_ARB_IDLE_ZERO_EN zeroes the gate operands in idle cycles so stale shares never reach the gate.
module msk_hpc2_arbiter #(
  parameter int d = 2,
  parameter int N = 4,
  localparam int hpc2rnd = d * (d - 1) / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*d-1:0]       req_ina,
  input  logic [N*d-1:0]       req_inb,
  input  logic [hpc2rnd-1:0]   rnd_in,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  output logic [d-1:0]         gate_ina,
  output logic [d-1:0]         gate_inb,
  output logic [hpc2rnd-1:0]   gate_rnd,
  input  logic [d-1:0]         gate_out,
  output logic [N-1:0]         resp_valid,
  output logic [d-1:0]         resp_out
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] r_ptr;
  logic          r_v1;
  logic [IW-1:0] r_idx1;
  logic          r_v2;
  logic [IW-1:0] r_idx2;
  logic [d-1:0]  r_ina;

  logic          w_found;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_next;
  logic          w_issue;
  logic [d-1:0]  w_inb_mux;

  // Scan starts at the pointer and wraps; the first asserted request wins.
  always_comb begin
    int unsigned idx;
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = IW'(idx);
      end
    end
  end

  assign w_next    = (w_win == IW'(N - 1)) ? '0 : w_win + 1'b1;
  assign w_issue   = !rst && rnd_valid && w_found;
  assign w_inb_mux = req_inb[int'(w_win)*d +: d];

  always_comb begin
    req_ready = '0;
    if (w_issue) req_ready[w_win] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if (r_v2 && !rst) resp_valid[r_idx2] = 1'b1;
  end

  assign rnd_ready = w_issue;
  assign resp_out  = gate_out;

`ifdef MSK_ARB_IDLE_ZERO_EN
  assign gate_inb = w_issue ? w_inb_mux : '0;
  assign gate_rnd = w_issue ? rnd_in : '0;
  assign gate_ina = r_v1 ? r_ina : '0;
`else
  assign gate_inb = w_inb_mux;
  assign gate_rnd = rnd_in;
  assign gate_ina = r_ina;
`endif

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_v1   <= 1'b0;
      r_idx1 <= '0;
      r_v2   <= 1'b0;
      r_idx2 <= '0;
      // NOTE: the share register is cleared too, so no pre-reset share can leak onto gate_ina.
      r_ina  <= '0;
    end else begin
      r_v1   <= w_issue;
      r_v2   <= r_v1;
      r_idx2 <= r_idx1;
      if (w_issue) begin
        r_ptr  <= w_next;
        r_idx1 <= w_win;
        r_ina  <= req_ina[int'(w_win)*d +: d];
      end
    end
  end

endmodule
